// File: rtl/fpga_test_port_arbiter.sv
// Round-robin arbiter that hands a shared 8-bit FPGA test port to one of
// four requesters at a time.
//
// Ports:
//   i_CLK         clock, all logic on the rising edge
//   i_RESET_n     asynchronous active-low reset
//   iv_REQ[3:0]   per-requester request, held high for the whole ownership
//   iv_DATA[31:0] packed per-requester test data, requester k on [8k+7:8k]
//   ov_GNT[3:0]   one-hot grant, or zero
//   ov_OWNER[1:0] index of the current or last owner
//   ov_FPGA_TEST  registered shared test-port value
//   o_LED         high while a grant is active
//   o_TIMEOUT     one-cycle pulse when a grant is revoked by the timer
//
// Parameters:
//   TIMEOUT_CYCLES  maximum grant length in cycles, 0 disables the timeout
//   IDLE_VALUE      value driven on ov_FPGA_TEST when nobody owns the port

module fpga_test_port_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
    parameter logic [7:0]  IDLE_VALUE     = 8'h00
) (
    input  logic        i_CLK,
    input  logic        i_RESET_n,
    input  logic [3:0]  iv_REQ,
    input  logic [31:0] iv_DATA,
    output logic [3:0]  ov_GNT,
    output logic [1:0]  ov_OWNER,
    output logic [7:0]  ov_FPGA_TEST,
    output logic        o_LED,
    output logic        o_TIMEOUT
);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StGap
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  owner_q, owner_d;
    logic [7:0]  test_q, test_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  block_q, block_d;
    logic        timeout_q, timeout_d;
    // Goes high on the first edge after reset release, so the earliest
    // possible grant is on the second edge.
    logic        rdy_q;

    logic [3:0]  elig;
    logic        found;
    logic [1:0]  winner;
    logic [1:0]  idx;
    logic        owner_req;
    logic [7:0]  owner_slice;

    assign elig        = iv_REQ & ~block_q;
    assign owner_req   = iv_REQ[owner_q];
    assign owner_slice = iv_DATA[{owner_q, 3'b000} +: 8];

    // Round-robin search starting just after the last owner.
    always_comb begin
        found  = 1'b0;
        winner = owner_q;
        idx    = '0;
        for (int i = 0; i < 4; i++) begin
            idx = owner_q + 2'(i + 1);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        test_d    = IDLE_VALUE;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        // A block flag only clears once its request is seen low.
        block_d   = block_q & iv_REQ;

        unique case (state_q)
            StIdle: begin
                if (rdy_q && found) begin
                    state_d = StGrant;
                    gnt_d   = 4'b0001 << winner;
                    owner_d = winner;
                    timer_d = '0;
                end
            end
            StGrant: begin
                timer_d = timer_q + 16'd1;
                if (!owner_req) begin
                    // A release wins over a coincident timeout.
                    state_d = StGap;
                    gnt_d   = '0;
                end else if ((TIMEOUT_CYCLES != 16'd0) &&
                             (timer_q == TIMEOUT_CYCLES - 16'd1)) begin
                    state_d          = StGap;
                    gnt_d            = '0;
                    timeout_d        = 1'b1;
                    block_d[owner_q] = 1'b1;
                end else begin
                    test_d = owner_slice;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            owner_q   <= 2'd3;
            test_q    <= IDLE_VALUE;
            timer_q   <= '0;
            block_q   <= '0;
            timeout_q <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            test_q    <= test_d;
            timer_q   <= timer_d;
            block_q   <= block_d;
            timeout_q <= timeout_d;
            rdy_q     <= 1'b1;
        end
    end

    assign ov_GNT       = gnt_q;
    assign ov_OWNER     = owner_q;
    assign ov_FPGA_TEST = test_q;
    assign o_LED        = |gnt_q;
    assign o_TIMEOUT    = timeout_q;

endmodule

// File: tb/tb_fpga_test_port_arbiter.sv
module tb_fpga_test_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  test;
    logic        led;
    logic        tmo;

    int total = 0;
    int bad   = 0;

    fpga_test_port_arbiter #(
        .TIMEOUT_CYCLES(16'd8),
        .IDLE_VALUE    (8'h00)
    ) dut (
        .i_CLK       (clk),
        .i_RESET_n   (rst_n),
        .iv_REQ      (req),
        .iv_DATA     (data),
        .ov_GNT      (gnt),
        .ov_OWNER    (owner),
        .ov_FPGA_TEST(test),
        .o_LED       (led),
        .o_TIMEOUT   (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic [7:0]  test;
        logic        led;
    } vec_t;

    vec_t vecs[17];
    int   ord[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single request, round-robin hand-over, late requests ignored.
        vecs[0]  = '{4'b0100, 32'h00A5_0000, 4'b0000, 2'd3, 8'h00, 1'b0};
        vecs[1]  = '{4'b0100, 32'h00A5_0000, 4'b0100, 2'd2, 8'h00, 1'b1};
        vecs[2]  = '{4'b0100, 32'h00A5_0000, 4'b0100, 2'd2, 8'hA5, 1'b1};
        vecs[3]  = '{4'b0100, 32'h003C_0000, 4'b0100, 2'd2, 8'h3C, 1'b1};
        vecs[4]  = '{4'b0000, 32'h003C_0000, 4'b0000, 2'd2, 8'h00, 1'b0};
        vecs[5]  = '{4'b0000, 32'h003C_0000, 4'b0000, 2'd2, 8'h00, 1'b0};
        vecs[6]  = '{4'b0011, 32'h0000_BBAA, 4'b0001, 2'd0, 8'h00, 1'b1};
        vecs[7]  = '{4'b0011, 32'h0000_BBAA, 4'b0001, 2'd0, 8'hAA, 1'b1};
        vecs[8]  = '{4'b0010, 32'h0000_BBAA, 4'b0000, 2'd0, 8'h00, 1'b0};
        vecs[9]  = '{4'b0010, 32'h0000_BBAA, 4'b0000, 2'd0, 8'h00, 1'b0};
        vecs[10] = '{4'b0010, 32'h0000_BBAA, 4'b0010, 2'd1, 8'h00, 1'b1};
        vecs[11] = '{4'b0110, 32'h00CC_BBAA, 4'b0010, 2'd1, 8'hBB, 1'b1};
        vecs[12] = '{4'b0100, 32'h00CC_BBAA, 4'b0000, 2'd1, 8'h00, 1'b0};
        vecs[13] = '{4'b0100, 32'h00CC_BBAA, 4'b0000, 2'd1, 8'h00, 1'b0};
        vecs[14] = '{4'b0100, 32'h00CC_BBAA, 4'b0100, 2'd2, 8'h00, 1'b1};
        vecs[15] = '{4'b0000, 32'h00CC_BBAA, 4'b0000, 2'd2, 8'h00, 1'b0};
        vecs[16] = '{4'b0000, 32'h00CC_BBAA, 4'b0000, 2'd2, 8'h00, 1'b0};
        ord = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        req   = '0;
        data  = '0;
        #12;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_owner", owner, 2'd3);
        chk("rst_test", test, 8'h00);
        chk("rst_led", led, 1'b0);
        chk("rst_tmo", tmo, 1'b0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int v = 0; v < 17; v++) begin
            req  = vecs[v].req;
            data = vecs[v].data;
            step();
            chk($sformatf("vec%0d_gnt", v), gnt, vecs[v].gnt);
            chk($sformatf("vec%0d_owner", v), owner, vecs[v].owner);
            chk($sformatf("vec%0d_test", v), test, vecs[v].test);
            chk($sformatf("vec%0d_led", v), led, vecs[v].led);
            chk($sformatf("vec%0d_tmo", v), tmo, 1'b0);
        end

        // Timeout: requester 1 holds for longer than 8 cycles.
        req  = 4'b0010;
        data = 32'h0000_5A00;
        step();
        chk("to_grant", gnt, 4'b0010);
        for (int c = 2; c <= 8; c++) begin
            step();
            chk($sformatf("to_hold%0d", c), gnt, 4'b0010);
            chk($sformatf("to_nopulse%0d", c), tmo, 1'b0);
        end
        chk("to_data", test, 8'h5A);
        step();
        chk("to_revoked", gnt, 4'b0000);
        chk("to_pulse", tmo, 1'b1);
        chk("to_gap_test", test, 8'h00);
        step();
        chk("to_pulse_end", tmo, 1'b0);
        step();
        step();
        chk("to_blocked", gnt, 4'b0000);
        // A blocked requester must not starve the others.
        req  = 4'b1010;
        data = 32'h7700_5A00;
        step();
        chk("to_other_gnt", gnt, 4'b1000);
        chk("to_other_owner", owner, 2'd3);
        req = 4'b0010;
        step();
        step();
        step();
        chk("to_still_blocked", gnt, 4'b0000);
        req = 4'b0000;
        step();
        req = 4'b0010;
        step();
        chk("to_regrant", gnt, 4'b0010);
        chk("to_regrant_owner", owner, 2'd1);
        req = 4'b0000;
        step();
        step();

        // Release coinciding with the timeout edge.
        req  = 4'b0100;
        data = 32'h00C3_0000;
        step();
        chk("co_grant", gnt, 4'b0100);
        for (int c = 2; c <= 8; c++) step();
        chk("co_cycle8", gnt, 4'b0100);
        req = 4'b0000;
        step();
        chk("co_gap", gnt, 4'b0000);
        chk("co_nopulse", tmo, 1'b0);
        step();
        chk("co_nopulse2", tmo, 1'b0);
        req = 4'b0100;
        step();
        chk("co_noblock", gnt, 4'b0100);
        step();
        chk("co_data", test, 8'hC3);

        // Asynchronous reset in the middle of a grant.
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt", gnt, 4'b0000);
        chk("ar_test", test, 8'h00);
        chk("ar_led", led, 1'b0);
        chk("ar_owner", owner, 2'd3);
        req  = 4'b1001;
        data = 32'h4433_2211;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("ar_first_edge", gnt, 4'b0000);
        step();

        // Round-robin with all four requesting, each releasing after 3 cycles.
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr%0d_gnt", i), gnt, 4'b0001 << ord[i]);
            chk($sformatf("rr%0d_owner", i), owner, ord[i]);
            chk($sformatf("rr%0d_led", i), led, 1'b1);
            if (i == 0) req = 4'b1111;
            step();
            chk($sformatf("rr%0d_data", i), test, 8'h11 * (ord[i] + 1));
            step();
            req[ord[i]] = 1'b0;
            step();
            chk($sformatf("rr%0d_gap", i), gnt, 4'b0000);
            chk($sformatf("rr%0d_gap_test", i), test, 8'h00);
            if (i < 4) req[ord[i]] = 1'b1;
            else req = 4'b0000;
            step();
            chk($sformatf("rr%0d_idle", i), gnt, 4'b0000);
            chk($sformatf("rr%0d_hold_owner", i), owner, ord[i]);
            if (i < 4) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
